// File: rtl/tx_dbf_ch_pkg.sv
// rtl/tx_dbf_ch_pkg.sv - shared widths and FSM state encoding for the transmit beamformer channel
package tx_dbf_ch_pkg;

  localparam int ADDR_WD = 7;
  localparam int DLY_WD  = 12;
  localparam int CYC_WD  = 4;
  localparam int HP_WD   = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/tx_dbf_ch_if.sv
// rtl/tx_dbf_ch_if.sv - fire/LUT-write/pulser signal bundle for the transmit beamformer channel
interface tx_dbf_ch_if #(
  parameter int ADDR_WD = tx_dbf_ch_pkg::ADDR_WD,
  parameter int DLY_WD  = tx_dbf_ch_pkg::DLY_WD,
  parameter int CYC_WD  = tx_dbf_ch_pkg::CYC_WD,
  parameter int HP_WD   = tx_dbf_ch_pkg::HP_WD
) ();

  logic               start;
  logic [ADDR_WD-1:0] line_addr;
  logic [ADDR_WD-1:0] lut_addr;
  logic               lut_we;
  logic [DLY_WD-1:0]  lut_din;
  logic [CYC_WD-1:0]  n_cycles;
  logic [HP_WD-1:0]   half_period;
  logic               tx_p;
  logic               tx_n;
  logic               tx_en;
  logic               busy;
  logic               done;

  modport master (
    output start, line_addr, lut_addr, lut_we, lut_din, n_cycles, half_period,
    input  tx_p, tx_n, tx_en, busy, done
  );

  modport slave (
    input  start, line_addr, lut_addr, lut_we, lut_din, n_cycles, half_period,
    output tx_p, tx_n, tx_en, busy, done
  );

endinterface

// File: rtl/tx_delay_lut.sv
// rtl/tx_delay_lut.sv - per-line focus delay RAM, one write port and one registered read port
module tx_delay_lut #(
  parameter int ADDR_WD = tx_dbf_ch_pkg::ADDR_WD,
  parameter int DLY_WD  = tx_dbf_ch_pkg::DLY_WD
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_WD-1:0] wr_addr,
  input  logic [DLY_WD-1:0]  wr_data,
  input  logic [ADDR_WD-1:0] rd_addr,
  output logic [DLY_WD-1:0]  rd_data_q
);

  localparam int DEPTH = 1 << ADDR_WD;

  logic [DLY_WD-1:0] mem_q [DEPTH];

  // Read-first RAM: a same-address write this cycle is not visible until the next read.
  // Contents are deliberately not reset so delay tables survive a channel reset.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr];
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/tx_dbf_ch.sv
// rtl/tx_dbf_ch.sv - one transmit channel: per-line focus delay followed by a bipolar pulse burst
module tx_dbf_ch #(
  parameter int ADDR_WD = tx_dbf_ch_pkg::ADDR_WD,
  parameter int DLY_WD  = tx_dbf_ch_pkg::DLY_WD,
  parameter int CYC_WD  = tx_dbf_ch_pkg::CYC_WD,
  parameter int HP_WD   = tx_dbf_ch_pkg::HP_WD
) (
  input  logic         clk,
  input  logic         rst_n,
  tx_dbf_ch_if.slave   bus
);

  import tx_dbf_ch_pkg::*;

  state_e             state_q, state_d;
  logic [ADDR_WD-1:0] line_q, line_d;
  logic [ADDR_WD-1:0] rd_addr;
  logic [CYC_WD-1:0]  ncyc_q, ncyc_d;
  logic [CYC_WD-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [HP_WD-1:0]   hp_q, hp_d;
  logic [HP_WD-1:0]   hp_cnt_q, hp_cnt_d;
  logic [DLY_WD-1:0]  dly_q, dly_d;
  logic [DLY_WD-1:0]  lut_rd;
  logic               phase_q, phase_d;
  logic               tx_p_q, tx_p_d;
  logic               tx_n_q, tx_n_d;
  logic               tx_en_q, tx_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // In IDLE the RAM reads the incoming line so its delay is ready during LOAD.
  assign rd_addr = (state_q == S_IDLE) ? bus.line_addr : line_q;

  tx_delay_lut #(
    .ADDR_WD (ADDR_WD),
    .DLY_WD  (DLY_WD)
  ) u_lut (
    .clk       (clk),
    .wr_en     (bus.lut_we),
    .wr_addr   (bus.lut_addr),
    .wr_data   (bus.lut_din),
    .rd_addr   (rd_addr),
    .rd_data_q (lut_rd)
  );

  // State, counters and registered outputs; reset kills any burst on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      ncyc_q    <= '0;
      cyc_cnt_q <= '0;
      hp_q      <= '0;
      hp_cnt_q  <= '0;
      dly_q     <= '0;
      phase_q   <= 1'b0;
      tx_p_q    <= 1'b0;
      tx_n_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      ncyc_q    <= ncyc_d;
      cyc_cnt_q <= cyc_cnt_d;
      hp_q      <= hp_d;
      hp_cnt_q  <= hp_cnt_d;
      dly_q     <= dly_d;
      phase_q   <= phase_d;
      tx_p_q    <= tx_p_d;
      tx_n_q    <= tx_n_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state plus delay and burst counters; start is only looked at in IDLE, so it never queues.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    ncyc_d    = ncyc_q;
    cyc_cnt_d = cyc_cnt_q;
    hp_d      = hp_q;
    hp_cnt_d  = hp_cnt_q;
    dly_d     = dly_q;
    phase_d   = phase_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          line_d  = bus.line_addr;
          ncyc_d  = bus.n_cycles;
          hp_d    = (bus.half_period == '0) ? HP_WD'(1) : bus.half_period;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dly_d     = lut_rd;
        hp_cnt_d  = HP_WD'(1);
        cyc_cnt_d = CYC_WD'(1);
        phase_d   = 1'b0;
        if (ncyc_q == '0) begin
          state_d = S_DONE;
        end else if (lut_rd == '0) begin
          state_d = S_PULSE;
        end else begin
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (dly_q == DLY_WD'(1)) begin
          state_d = S_PULSE;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (hp_cnt_q == hp_q) begin
          hp_cnt_d = HP_WD'(1);
          phase_d  = ~phase_q;
          if (phase_q) begin
            if (cyc_cnt_q == ncyc_q) begin
              state_d = S_DONE;
            end else begin
              cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state; registered, so pins lag the state by one clock.
  always_comb begin
    tx_p_d  = (state_q == S_PULSE) && !phase_q;
    tx_n_d  = (state_q == S_PULSE) && phase_q;
    tx_en_d = (state_q == S_PULSE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_DONE);
  end

  assign bus.tx_p  = tx_p_q;
  assign bus.tx_n  = tx_n_q;
  assign bus.tx_en = tx_en_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_tx_dbf_ch.sv
// tb/tb_tx_dbf_ch.sv - self-checking bench for the transmit beamformer channel
module tb_tx_dbf_ch;

  import tx_dbf_ch_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   lut_m [128];

  tx_dbf_ch_if bus ();

  tx_dbf_ch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int d;
    int n;
    int hp;
    int exp_rise;
    int exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Edge offset (from the start edge) at which done is expected.
  function automatic int model_done(input int n, input int hp, input int d);
    int h;
    h = (hp == 0) ? 1 : hp;
    return (n == 0) ? 2 : 2 + d + 2 * h * n;
  endfunction

  // Expected {tx_p, tx_n, tx_en, busy, done} just after edge k+j.
  function automatic logic [4:0] model_out(input int j, input int n, input int hp, input int d);
    int h, p, dn, o;
    logic tp, tn;
    h  = (hp == 0) ? 1 : hp;
    p  = 2 + d;
    dn = model_done(n, hp, d);
    tp = 1'b0;
    tn = 1'b0;
    if (n != 0 && j >= p && j < dn) begin
      o  = (j - p) % (2 * h);
      tp = (o < h);
      tn = !tp;
    end
    return {tp, tn, tp | tn, (j >= 0 && j < dn), (j == dn)};
  endfunction

  function automatic logic [4:0] outs();
    return {bus.tx_p, bus.tx_n, bus.tx_en, bus.busy, bus.done};
  endfunction

  task automatic lut_write(input int a, input int v);
    bus.lut_addr = ADDR_WD'(a);
    bus.lut_din  = DLY_WD'(v);
    bus.lut_we   = 1'b1;
    @(posedge clk); #1;
    bus.lut_we   = 1'b0;
    lut_m[a]     = v;
  endtask

  // Fire one line and compare every cycle against the model; optionally inject a
  // start plus a same-address LUT write at offset inj_j.
  task automatic run_line(input int addr, input int n, input int hp, input int d,
                          input int exp_rise, input int exp_done,
                          input int inj_j, input int inj_val, input string name);
    int dn, rise, dj;
    dn   = model_done(n, hp, d);
    rise = -1;
    dj   = -1;
    bus.line_addr   = ADDR_WD'(addr);
    bus.n_cycles    = CYC_WD'(n);
    bus.half_period = HP_WD'(hp);
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int j = 0; j <= dn + 2; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.lut_we = 1'b0;
      end
      check($sformatf("%s wave j=%0d", name, j), 32'(outs()), 32'(model_out(j, n, hp, d)));
      if (bus.tx_p && rise < 0) rise = j;
      if (bus.done && dj < 0) dj = j;
      if (j == inj_j) begin
        bus.start       = 1'b1;
        bus.n_cycles    = CYC_WD'(n + 2);
        bus.half_period = HP_WD'(hp + 1);
        bus.lut_addr    = ADDR_WD'(addr);
        bus.lut_din     = DLY_WD'(inj_val);
        bus.lut_we      = 1'b1;
        lut_m[addr]     = inj_val;
      end
    end
    check($sformatf("%s first tx_p", name), 32'(rise), 32'(exp_rise));
    check($sformatf("%s done edge", name), 32'(dj), 32'(exp_done));
  endtask

  // Pulser safety invariants on every cycle.
  always @(negedge clk) begin
    check("tx_p and tx_n exclusive", 32'(bus.tx_p & bus.tx_n), 32'd0);
    check("tx_en equals tx_p|tx_n", 32'(bus.tx_en), 32'(bus.tx_p | bus.tx_n));
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int addr, n, hp;
    n_total = 0;
    n_pass  = 0;
    vecs[0] = '{addr: 5,   d: 10,   n: 2,  hp: 3,  exp_rise: 12,   exp_done: 24};
    vecs[1] = '{addr: 0,   d: 0,    n: 1,  hp: 0,  exp_rise: 2,    exp_done: 4};
    vecs[2] = '{addr: 3,   d: 9,    n: 0,  hp: 2,  exp_rise: -1,   exp_done: 2};
    vecs[3] = '{addr: 9,   d: 1,    n: 1,  hp: 1,  exp_rise: 3,    exp_done: 5};
    vecs[4] = '{addr: 2,   d: 2,    n: 3,  hp: 2,  exp_rise: 4,    exp_done: 16};
    vecs[5] = '{addr: 64,  d: 3,    n: 15, hp: 63, exp_rise: 5,    exp_done: 1895};
    vecs[6] = '{addr: 127, d: 4095, n: 1,  hp: 1,  exp_rise: 4097, exp_done: 4099};

    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.line_addr   = '0;
    bus.lut_addr    = '0;
    bus.lut_we      = 1'b0;
    bus.lut_din     = '0;
    bus.n_cycles    = '0;
    bus.half_period = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'(outs()), 32'd0);

    // The LUT is writable during reset; preload every entry.
    for (int i = 0; i < 128; i++) lut_write(i, i % 16);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle outputs", 32'(outs()), 32'd0);

    for (int v = 0; v < 7; v++) begin
      lut_write(vecs[v].addr, vecs[v].d);
      run_line(vecs[v].addr, vecs[v].n, vecs[v].hp, vecs[v].d,
               vecs[v].exp_rise, vecs[v].exp_done, -1, 0, $sformatf("vec%0d", v));
    end

    // Ignored start and same-line LUT rewrite during DELAY.
    lut_write(7, 20);
    run_line(7, 1, 2, 20, 22, 26, 5, 4, "delay_restart");
    run_line(7, 1, 2, 4, 6, 10, -1, 0, "after_rewrite");

    // Reset during the second tx_p half-cycle of the line-5 burst.
    bus.line_addr   = ADDR_WD'(5);
    bus.n_cycles    = CYC_WD'(2);
    bus.half_period = HP_WD'(3);
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int j = 1; j <= 18; j++) begin
      @(posedge clk); #1;
    end
    check("pre-reset tx_p", 32'(bus.tx_p), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset mid-burst outputs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      check($sformatf("no resume j=%0d", j), 32'(outs()), 32'd0);
    end
    run_line(5, 2, 3, lut_m[5], 12, 24, -1, 0, "refire_after_reset");

    // Random fires against the model.
    for (int i = 0; i < 1000; i++) begin
      addr = int'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) lut_write(addr, int'($urandom_range(0, 20)));
      n  = int'($urandom_range(0, 4));
      hp = int'($urandom_range(0, 4));
      run_line(addr, n, hp, lut_m[addr], (n == 0) ? -1 : 2 + lut_m[addr],
               model_done(n, hp, lut_m[addr]), -1, 0, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tx_dbf_ch.md
TX_DBF_CH -- requirements
Module: tx_dbf_ch

Interface
REQ-001 SHALL have parameter ADDR_WD, default 7: scan-line LUT address width (128 lines).
REQ-002 SHALL have parameter DLY_WD, default 12: transmit focus delay width, in clock cycles.
REQ-003 SHALL have parameter CYC_WD, default 4: pulse-cycle count width.
REQ-004 SHALL have parameter HP_WD, default 6: pulse half-period width, in clocks.
REQ-005 SHALL have one clock and a synchronous, active-low reset, with ports as follows.
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have the remaining ports:
- start  in  1  scan-line fire trigger, one-cycle pulse.
- line_addr  in  ADDR_WD  scan line to fire; sampled with start.
- lut_addr  in  ADDR_WD  delay LUT write address.
- lut_we  in  1  delay LUT write enable.
- lut_din  in  DLY_WD  delay value to write.
- n_cycles  in  CYC_WD  pulse cycles per burst; sampled with start.
- half_period  in  HP_WD  clocks per pulse half-cycle; sampled with start.
- tx_p  out  1  positive pulser drive.
- tx_n  out  1  negative pulser drive.
- tx_en  out  1  high while the burst is active; gates the receive channel.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle end-of-line pulse.

Function
REQ-007 SHALL hold a 2^ADDR_WD x DLY_WD delay LUT: synchronous write on lut_we, registered read with 1-cycle latency.
REQ-008 SHALL implement the FSM IDLE -> LOAD -> DELAY -> PULSE -> DONE -> IDLE.
REQ-009 SHALL, in IDLE on start, latch line_addr, n_cycles and half_period, then enter LOAD.
- A half_period of 0 SHALL be latched as 1.
REQ-010 SHALL, in LOAD (1 cycle), capture the LUT read D into the delay counter.
- D = 0: go straight to PULSE.
- n_cycles = 0: go straight to DONE.
REQ-011 SHALL, in DELAY, decrement the counter each cycle and enter PULSE when it reaches 1.
- With start sampled at edge k, tx_p SHALL first rise at edge k+2+D.
REQ-012 SHALL, in PULSE, drive tx_p high for HP clocks, then tx_n high for HP clocks; this is one cycle, repeated n_cycles times, with no gap between cycles.
REQ-013 SHALL never assert tx_p and tx_n in the same cycle; both SHALL be low outside PULSE.
REQ-014 SHALL assert tx_en exactly in the cycles where tx_p or tx_n is high.
REQ-015 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE.
REQ-016 SHALL ignore start while busy; an ignored start SHALL NOT be queued.
REQ-017 SHALL accept LUT writes in any state; the in-flight line SHALL use the delay value captured in LOAD.
- A write and a read of the same address in the same cycle SHALL return the old data (read-first).
REQ-018 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-019 SHALL, while rst_n = 0 at a clock edge, force IDLE and tx_p = tx_n = tx_en = busy = done = 0, and clear all counters.
REQ-020 SHALL let a reset during PULSE drop tx_p and tx_n at that same edge; the burst SHALL NOT resume.
REQ-021 SHALL NOT clear LUT contents on reset.

Structure
REQ-022 SHALL place ADDR_WD, DLY_WD, CYC_WD, HP_WD and the FSM state encodings in the shared parameter header.
REQ-023 SHALL factor the delay LUT into one sub-module, tx_delay_lut (simple dual-port RAM: write port and read port).

Verification
REQ-024 Write LUT[5] = 10; start with line_addr = 5, n_cycles = 2, half_period = 3 at edge k -> tx_p high at k+12..k+14, tx_n high at k+15..k+17, tx_p high at k+18..k+20, tx_n high at k+21..k+23, done high at k+24.
REQ-025 LUT[0] = 0, n_cycles = 1, half_period = 0 -> tx_p high 1 clock at k+2, tx_n high 1 clock at k+3, done high at k+4.
REQ-026 n_cycles = 0 -> no tx_p, tx_n or tx_en activity; done high at k+2.
REQ-027 Second start during DELAY, plus a write to the active line's address during DELAY -> second start ignored; timing unchanged; the next line uses the new value.
REQ-028 Drop rst_n to 0 during the 2nd tx_p half-cycle -> all outputs 0 at that edge; state IDLE; LUT contents retained on re-fire.
REQ-029 Run 1000 random fires -> tx_p and tx_n are never high together, and tx_en always equals (tx_p OR tx_n).
